// File: rtl/conv11_weight_ctrl.sv
// conv11_weight_ctrl: sequences a 1x1-conv weight unit through one layer.
// For each output channel it clears the unit, loads one weight from the
// upstream stream, issues NUM_PIX reads (honouring downstream stall), waits
// for every read result to come back, then moves to the next channel.
module conv11_weight_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_OC     = 16,
  parameter int NUM_PIX    = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       w_valid,
  input  logic [DATA_WIDTH-1:0]      w_data,
  output logic                       w_ready,
  input  logic                       pix_stall,
  output logic                       wt_rst,
  output logic                       wt_load_en,
  output logic [DATA_WIDTH-1:0]      wt_load_data,
  output logic                       wt_read_en,
  input  logic                       wt_weight_load,
  input  logic                       wt_valid,
  output logic [$clog2(NUM_OC)-1:0]  oc_idx,
  output logic [$clog2(NUM_PIX)-1:0] pix_idx,
  output logic                       busy,
  output logic                       ch_done,
  output logic                       done,
  output logic                       err
);

  localparam int OW = $clog2(NUM_OC);
  localparam int PW = $clog2(NUM_PIX);
  localparam int VW = $clog2(NUM_PIX + 1);

  localparam logic [OW-1:0] OC_LAST   = OW'(NUM_OC - 1);
  localparam logic [PW-1:0] PIX_LAST  = PW'(NUM_PIX - 1);
  localparam logic [VW-1:0] VLD_FULL  = VW'(NUM_PIX);
  localparam logic [VW-1:0] VLD_PRE   = VW'(NUM_PIX - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_LOAD, S_WAIT_LD, S_READ, S_DRAIN, S_NEXT, S_DONE
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [VW-1:0]   vld_cnt;
  logic            in_rd;
  logic            start_acc;
  logic            rd_issue;
  logic            vld_last;
  logic            err_set;

  // Read results are only legal while reads are outstanding.
  assign in_rd        = (state == S_READ) || (state == S_DRAIN);
  assign start_acc    = (state == S_IDLE) && start && !abort;
  assign rd_issue     = (state == S_READ) && !pix_stall;
  assign wt_read_en   = rd_issue;
  assign wt_load_en   = w_ready & w_valid;
  assign wt_load_data = w_data;
  // Last result of the channel is either already counted or arriving now.
  assign vld_last     = (vld_cnt == VLD_FULL) || (wt_valid && (vld_cnt == VLD_PRE));
  assign err_set      = (wt_valid && (!in_rd || (vld_cnt == VLD_FULL))) ||
                        (wt_weight_load && (state != S_WAIT_LD));

  // Next-state selection; abort overrides every other transition.
  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (start) state_nx = S_CLR;
        S_CLR:     state_nx = S_LOAD;
        S_LOAD:    if (w_valid) state_nx = S_WAIT_LD;
        S_WAIT_LD: if (wt_weight_load) state_nx = S_READ;
        S_READ:    if (rd_issue && (pix_idx == PIX_LAST)) state_nx = S_DRAIN;
        S_DRAIN:   if (vld_last) state_nx = S_NEXT;
        S_NEXT:    state_nx = (oc_idx == OC_LAST) ? S_DONE : S_CLR;
        S_DONE:    state_nx = S_IDLE;
        default:   state_nx = S_IDLE;
      endcase
    end
  end

  // State, counters, sticky error and registered outputs decoded from next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      oc_idx  <= '0;
      pix_idx <= '0;
      vld_cnt <= '0;
      err     <= 1'b0;
      w_ready <= 1'b0;
      wt_rst  <= 1'b0;
      busy    <= 1'b0;
      ch_done <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      w_ready <= (state_nx == S_LOAD);
      wt_rst  <= (state_nx == S_CLR) || abort;
      busy    <= (state_nx != S_IDLE);
      ch_done <= (state_nx == S_NEXT);
      done    <= (state_nx == S_DONE);

      if (start_acc) begin
        oc_idx <= '0;
      end else if ((state == S_NEXT) && !abort && (oc_idx != OC_LAST)) begin
        oc_idx <= oc_idx + 1'b1;
      end

      if (state == S_CLR) begin
        pix_idx <= '0;
      end else if (rd_issue && (pix_idx != PIX_LAST)) begin
        pix_idx <= pix_idx + 1'b1;
      end

      if (state == S_CLR) begin
        vld_cnt <= '0;
      end else if (in_rd && wt_valid && (vld_cnt != VLD_FULL)) begin
        vld_cnt <= vld_cnt + 1'b1;
      end

      // A fresh layer clears the flag, but a violation in the same cycle still sticks.
      err <= (start_acc ? 1'b0 : err) | err_set;
    end
  end

endmodule

// File: tb/tb_conv11_weight_ctrl.sv
// Bench for conv11_weight_ctrl with NUM_OC=2, NUM_PIX=4. A small weight-unit
// model answers a load one cycle later and returns each read two cycles later;
// it drops anything in flight when cleared. Expected per-cycle outputs come
// from a channel-by-channel timeline walk over the stimulus arrays.
module tb_conv11_weight_ctrl;

  localparam int DW   = 8;
  localparam int NOC  = 2;
  localparam int NPX  = 4;
  localparam int MAXC = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic          w_valid;
  logic [DW-1:0] w_data;
  logic          w_ready;
  logic          pix_stall;
  logic          wt_rst;
  logic          wt_load_en;
  logic [DW-1:0] wt_load_data;
  logic          wt_read_en;
  logic          wt_weight_load;
  logic          wt_valid;
  logic [0:0]    oc_idx;
  logic [1:0]    pix_idx;
  logic          busy;
  logic          ch_done;
  logic          done;
  logic          err;

  conv11_weight_ctrl #(.DATA_WIDTH(DW), .NUM_OC(NOC), .NUM_PIX(NPX)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .pix_stall(pix_stall), .wt_rst(wt_rst), .wt_load_en(wt_load_en),
    .wt_load_data(wt_load_data), .wt_read_en(wt_read_en),
    .wt_weight_load(wt_weight_load), .wt_valid(wt_valid),
    .oc_idx(oc_idx), .pix_idx(pix_idx), .busy(busy),
    .ch_done(ch_done), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Weight-unit model
  logic wl_q, v1, v2, inj_v, inj_wl;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wl_q <= 1'b0; v1 <= 1'b0; v2 <= 1'b0;
    end else if (wt_rst) begin
      wl_q <= 1'b0; v1 <= 1'b0; v2 <= 1'b0;
    end else begin
      wl_q <= wt_load_en; v1 <= wt_read_en; v2 <= v1;
    end
  end
  assign wt_weight_load = wl_q | inj_wl;
  assign wt_valid       = (v2 & ~wt_rst) | inj_v;

  // Stimulus and expectation arrays, indexed by cycle from start
  bit            wv [MAXC];
  bit            st [MAXC];
  logic [DW-1:0] wd [MAXC];
  bit e_busy[MAXC], e_rdy[MAXC], e_rst[MAXC], e_ld[MAXC], e_rd[MAXC];
  bit e_chd[MAXC], e_done[MAXC], e_err[MAXC];
  logic [0:0] e_oc [MAXC];
  logic [1:0] e_pix[MAXC];

  int vec = 0;
  int mis = 0;
  int prev_oc = 0, prev_pix = 0;
  bit prev_err = 1'b0;
  int g_rd, g_rst, g_chd, g_done_n, g_done_cyc, g_rdy, g_ld_n;
  logic [DW-1:0] g_ld [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] obs_pack();
    return {busy, w_ready, wt_rst, wt_load_en, wt_read_en, ch_done, done, err, oc_idx, pix_idx};
  endfunction

  function automatic void mark(input int t, input int o, input int p);
    e_busy[t] = 1'b1;
    e_oc[t]   = 1'(o);
    e_pix[t]  = 2'(p);
  endfunction

  // Walk the layer channel by channel over the stimulus arrays.
  task automatic model_build(input int abort_at, output int ncyc);
    int t, last, n, o, p;
    for (int i = 0; i < MAXC; i++) begin
      e_busy[i] = 0; e_rdy[i] = 0; e_rst[i] = 0; e_ld[i] = 0; e_rd[i] = 0;
      e_chd[i] = 0; e_done[i] = 0; e_err[i] = 0; e_oc[i] = '0; e_pix[i] = '0;
    end
    e_oc[0] = 1'(prev_oc); e_pix[0] = 2'(prev_pix); e_err[0] = prev_err;
    o = 0; p = prev_pix; t = 1;
    for (int ch = 0; ch < NOC; ch++) begin
      mark(t, o, p); e_rst[t] = 1; t++; p = 0;
      while (1) begin
        mark(t, o, p); e_rdy[t] = 1;
        if (wv[t]) begin e_ld[t] = 1; t++; break; end
        t++;
      end
      mark(t, o, p); t++;
      n = 0; last = t;
      while (n < NPX) begin
        mark(t, o, p);
        if (!st[t]) begin e_rd[t] = 1; n++; if (p < NPX - 1) p++; last = t; end
        t++;
      end
      while (t <= last + 2) begin mark(t, o, p); t++; end
      mark(t, o, p); e_chd[t] = 1; t++;
      if (ch < NOC - 1) o++;
    end
    mark(t, o, p); e_done[t] = 1; t++;
    ncyc = t + 3;
    for (int i = t; i < ncyc; i++) begin e_oc[i] = 1'(o); e_pix[i] = 2'(p); end
    if (abort_at > 0) begin
      o = int'(e_oc[abort_at]);
      p = int'(e_pix[abort_at]);
      if (e_rd[abort_at] && p < NPX - 1) p++;
      for (int i = abort_at + 1; i < MAXC; i++) begin
        e_busy[i] = 0; e_rdy[i] = 0; e_rst[i] = 0; e_ld[i] = 0; e_rd[i] = 0;
        e_chd[i] = 0; e_done[i] = 0; e_oc[i] = 1'(o); e_pix[i] = 2'(p);
      end
      e_rst[abort_at + 1] = 1;
      ncyc = abort_at + 4;
    end
    prev_oc = o; prev_pix = p; prev_err = 1'b0;
  endtask

  task automatic run_layer(input int abort_at, input int stop_at);
    int ncyc;
    logic [10:0] ex;
    model_build(abort_at, ncyc);
    if (stop_at >= 0) ncyc = stop_at + 1;
    g_rd = 0; g_rst = 0; g_chd = 0; g_done_n = 0; g_done_cyc = -1; g_rdy = 0; g_ld_n = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      start     = (c == 0) || (e_busy[c] && ($urandom_range(3) == 0));
      abort     = (abort_at > 0) && (c == abort_at);
      w_valid   = wv[c];
      w_data    = wd[c];
      pix_stall = st[c];
      @(negedge clk);
      ex = {e_busy[c], e_rdy[c], e_rst[c], e_ld[c], e_rd[c], e_chd[c], e_done[c],
            e_err[c], e_oc[c], e_pix[c]};
      check($sformatf("cyc%0d", c), 32'(obs_pack()), 32'(ex));
      if (e_ld[c]) check($sformatf("ld_data%0d", c), 32'(wt_load_data), 32'(wd[c]));
      g_rd  += int'(wt_read_en);
      g_rst += int'(wt_rst);
      g_chd += int'(ch_done);
      g_rdy += int'(w_ready);
      if (done) begin g_done_n++; g_done_cyc = c; end
      if (wt_load_en && g_ld_n < 2) begin g_ld[g_ld_n] = wt_load_data; g_ld_n++; end
    end
    start = 1'b0; abort = 1'b0; w_valid = 1'b0; pix_stall = 1'b0;
  endtask

  task automatic gen_plain();
    for (int c = 0; c < MAXC; c++) begin
      wv[c] = 1'b1; st[c] = 1'b0; wd[c] = (c < 8) ? 8'h11 : 8'h22;
    end
  endtask

  task automatic gen_rand();
    for (int c = 0; c < MAXC; c++) begin
      wv[c] = (c >= 100) || ($urandom_range(2) != 0);
      st[c] = (c < 100) && ($urandom_range(3) == 0);
      wd[c] = 8'($urandom);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; w_valid = 1'b0; w_data = 8'h5A;
    pix_stall = 1'b0; inj_v = 1'b0; inj_wl = 1'b0;
    #2;
    check("reset_outs", 32'(obs_pack()), 32'd0);
    check("reset_ldata", 32'(wt_load_data), 32'h5A);
    w_data = 8'hC3; #1;
    check("reset_ldata_follow", 32'(wt_load_data), 32'hC3);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_reset_idle", 32'(obs_pack()), 32'd0);

    // Nominal layer: 0x11 then 0x22, no stall
    gen_plain();
    run_layer(0, -1);
    check("nom_done_cycle", 32'(g_done_cyc), 32'd21);
    check("nom_wt_rst", 32'(g_rst), 32'd2);
    check("nom_reads", 32'(g_rd), 32'd8);
    check("nom_ch_done", 32'(g_chd), 32'd2);
    check("nom_ld0", 32'(g_ld[0]), 32'h11);
    check("nom_ld1", 32'(g_ld[1]), 32'h22);

    // Stall for three cycles while pix_idx is 2 in channel 0
    gen_plain();
    st[6] = 1'b1; st[7] = 1'b1; st[8] = 1'b1;
    run_layer(0, -1);
    check("stall_done_cycle", 32'(g_done_cyc), 32'd24);
    check("stall_reads", 32'(g_rd), 32'd8);

    // Weight withheld five cycles in channel 0 LOAD
    gen_plain();
    for (int c = 2; c <= 6; c++) wv[c] = 1'b0;
    run_layer(0, -1);
    check("wgap_ready_cycles", 32'(g_rdy), 32'd7);
    check("wgap_done_n", 32'(g_done_n), 32'd1);

    // Abort during channel 1 READ, then a clean re-run
    gen_plain();
    run_layer(14, -1);
    check("abort_no_done", 32'(g_done_n), 32'd0);
    check("abort_ch_done", 32'(g_chd), 32'd1);
    gen_plain();
    run_layer(0, -1);
    check("rerun_done_n", 32'(g_done_n), 32'd1);

    // Spurious load-done in IDLE sets err until the next accepted start
    @(posedge clk); #1 inj_wl = 1'b1;
    @(posedge clk); #1 inj_wl = 1'b0;
    @(negedge clk);
    check("spur_wl_err", 32'(err), 32'd1);
    prev_err = 1'b1;
    gen_rand();
    run_layer(0, -1);

    // Spurious read-valid in IDLE
    @(posedge clk); #1 inj_v = 1'b1;
    @(posedge clk); #1 inj_v = 1'b0;
    @(negedge clk);
    check("spur_v_err", 32'(err), 32'd1);
    check("spur_v_idle", 32'(busy), 32'd0);
    prev_err = 1'b1;
    gen_plain();
    run_layer(0, -1);

    // Randomized layers
    for (int k = 0; k < 6; k++) begin
      gen_rand();
      run_layer(0, -1);
      check($sformatf("rand%0d_done_n", k), 32'(g_done_n), 32'd1);
    end

    // Asynchronous reset in the middle of channel 0 DRAIN
    gen_plain();
    run_layer(0, 8);
    #2 rst = 1'b1;
    #1;
    check("async_rst_outs", 32'(obs_pack()), 32'd0);
    check("async_rst_ldata", 32'(wt_load_data), 32'(w_data));
    @(posedge clk); #1 rst = 1'b0;
    prev_oc = 0; prev_pix = 0; prev_err = 1'b0;
    gen_plain();
    run_layer(0, -1);
    check("after_rst_done_cycle", 32'(g_done_cyc), 32'd21);
    check("after_rst_ch_done", 32'(g_chd), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule

// File: doc/conv11_weight_ctrl.md
CONV11_WEIGHT_CTRL -- requirements
Module: conv11_weight_ctrl

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, 8, weight width; NUM_OC, 16, output channels per layer; NUM_PIX, 64, pixels per channel.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  layer start request, sampled in IDLE only.
- abort  in  1  synchronous abort, any state.
- w_valid  in  1  upstream weight stream valid.
- w_data  in  DATA_WIDTH  upstream weight.
- w_ready  out  1  upstream weight accept.
- pix_stall  in  1  downstream backpressure; holds read issue.
- wt_rst  out  1  clear pulse to weight unit.
- wt_load_en  out  1  weight unit load enable.
- wt_load_data  out  DATA_WIDTH  weight unit load data.
- wt_read_en  out  1  weight unit read enable.
- wt_weight_load  in  1  weight unit load-done pulse.
- wt_valid  in  1  weight unit output-valid pulse.
- oc_idx  out  clog2(NUM_OC)  current output channel.
- pix_idx  out  clog2(NUM_PIX)  reads issued in current channel.
- busy  out  1  high outside IDLE.
- ch_done  out  1  one-cycle pulse per channel completed.
- done  out  1  one-cycle pulse at layer end.
- err  out  1  sticky protocol error.

Function
REQ-003 SHALL implement FSM states IDLE, CLR, LOAD, WAIT_LD, READ, DRAIN, NEXT, DONE.
REQ-004 IDLE: start=1 -> CLR, oc_idx<=0; start in any other state SHALL be ignored.
REQ-005 CLR: wt_rst=1 for exactly one cycle, pix_idx<=0, vld_cnt<=0 -> LOAD.
REQ-006 LOAD: w_ready=1; wt_load_en = w_valid, wt_load_data = w_data (combinational); on w_valid -> WAIT_LD. Outside LOAD, w_ready=0 and wt_load_en=0.
REQ-007 WAIT_LD: wait for wt_weight_load=1 -> READ; no timeout.
REQ-008 READ: wt_read_en = !pix_stall; each issued read increments pix_idx; the cycle issuing read NUM_PIX-1 -> DRAIN; pix_stall SHALL hold pix_idx unchanged.
REQ-009 Internal vld_cnt SHALL count wt_valid pulses in READ and DRAIN; DRAIN -> NEXT when vld_cnt reaches NUM_PIX (including the arriving pulse).
REQ-010 NEXT: ch_done=1 one cycle; if oc_idx==NUM_OC-1 -> DONE, else oc_idx+1 -> CLR.
REQ-011 DONE: done=1 one cycle -> IDLE; oc_idx holds final value until next start.
REQ-012 Minimum per-channel latency with w_valid and no stall: CLR 1 + LOAD 1 + WAIT_LD 1 + READ NUM_PIX + DRAIN 1 + NEXT 1 cycles.
REQ-013 abort=1 SHALL force IDLE next cycle from any state, assert wt_rst for that cycle, suppress done/ch_done; abort has priority over start and all transitions.
REQ-014 err SHALL set on: wt_valid outside READ/DRAIN, wt_valid when vld_cnt==NUM_PIX, wt_weight_load outside WAIT_LD; err clears only on rst or start accepted in IDLE.
REQ-015 Counters SHALL not wrap: pix_idx saturates at NUM_PIX-1, vld_cnt at NUM_PIX.

Reset
REQ-016 rst=1 SHALL asynchronously force state IDLE, oc_idx=0, pix_idx=0, vld_cnt=0, err=0, and outputs w_ready, wt_rst, wt_load_en, wt_read_en, busy, ch_done, done all 0; wt_load_data follows w_data.
REQ-017 rst mid-operation SHALL abandon the layer without pulsing done or ch_done; operation resumes only on a new start.

Verification (NUM_OC=2, NUM_PIX=4)
REQ-018 start, w_data 0x11 then 0x22 always valid, no stall, unit model echoes -> wt_rst pulses 2, wt_load_data 0x11 then 0x22, 8 wt_read_en cycles, ch_done 2, done 1 at cycle 21 after start, err=0.
REQ-019 pix_stall high 3 cycles at pix_idx=2 -> wt_read_en low those 3 cycles, pix_idx held at 2, channel completes 3 cycles later, total 4 reads.
REQ-020 w_valid withheld 5 cycles in LOAD -> w_ready high 6 cycles, one wt_load_en pulse, no wt_read_en before wt_weight_load.
REQ-021 abort in READ of channel 1 -> IDLE next cycle, wt_rst=1 that cycle, busy=0, no done; new start re-runs from oc_idx=0.
REQ-022 spurious wt_valid in IDLE -> err=1, stays 1 through the next layer until next start accepted, then 0.
REQ-023 rst asserted mid-DRAIN without clock edge -> all outputs at REQ-016 values immediately; start after deassert runs full layer normally.
